// File: rtl/vga_stream_driver.sv
// vga_stream_driver: parametrised VGA timing engine that pulls {r,g,b} pixels
// from a valid/ready stream and drives registered sync, colour and position
// outputs. Supports stream, colour-bar, masked-stream and blank modes.
module vga_stream_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [1:0]                                    mode,
    input  logic [3*COLOR_W-1:0]                          pix_data,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    input  logic                                          mask_bit,
    output logic                                          vga_hs,
    output logic                                          vga_vs,
    output logic [COLOR_W-1:0]                            vga_r,
    output logic [COLOR_W-1:0]                            vga_g,
    output logic [COLOR_W-1:0]                            vga_b,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] hcount,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] vcount,
    output logic                                          frame_start,
    output logic                                          underflow
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W     = $clog2(H_TOTAL);
    localparam int unsigned VC_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RGB_W    = 3 * COLOR_W;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_MASK   = 2'd2;

    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  h_q, h_d;
    logic [VC_W-1:0]  v_q, v_d;
    logic [1:0]       mode_q, mode_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [HC_W-1:0]  hcount_q, hcount_d;
    logic [VC_W-1:0]  vcount_q, vcount_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;

    logic             tick;
    logic             h_wrap;
    logic [HC_W-1:0]  h_nxt;
    logic [VC_W-1:0]  v_nxt;
    logic             frame_tick;
    logic             active;
    logic [1:0]       mode_eff;
    logic [2:0]       bar_k;

    // Pixel tick, next raster position, effective mode and upstream handshake
    always_comb begin
        tick       = en && (div_q == DIV_W'(CLK_DIV - 1));
        h_wrap     = (h_q == HC_W'(H_TOTAL - 1));
        h_nxt      = h_wrap ? '0 : h_q + HC_W'(1);
        v_nxt      = v_q;
        if (h_wrap) begin
            v_nxt = (v_q == VC_W'(V_TOTAL - 1)) ? '0 : v_q + VC_W'(1);
        end
        frame_tick = tick && (h_nxt == '0) && (v_nxt == '0);
        active     = (h_nxt < HC_W'(H_ACTIVE)) && (v_nxt < VC_W'(V_ACTIVE));
        // The mode sampled at the frame boundary already governs pixel (0,0)
        mode_eff   = frame_tick ? mode : mode_q;
        pix_ready  = tick && active && ((mode_eff == MODE_STREAM) || (mode_eff == MODE_MASK));
        bar_k      = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h_nxt >= HC_W'(i * BAR_W)) begin
                bar_k = 3'(i);
            end
        end
    end

    // Next-state: all output registers load together for the new position
    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        mode_d        = mode_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        rgb_d         = rgb_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        underflow_d   = underflow_q;
        frame_start_d = 1'b0;

        if (en) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (tick) begin
            h_d           = h_nxt;
            v_d           = v_nxt;
            hcount_d      = h_nxt;
            vcount_d      = v_nxt;
            frame_start_d = frame_tick;
            if (frame_tick) begin
                mode_d = mode;
            end
            hs_d = ((h_nxt >= HC_W'(HS_FIRST)) && (h_nxt <= HC_W'(HS_LAST))) ? HS_POL : ~HS_POL;
            vs_d = ((v_nxt >= VC_W'(VS_FIRST)) && (v_nxt <= VC_W'(VS_LAST))) ? VS_POL : ~VS_POL;

            rgb_d = '0;
            if (active) begin
                case (mode_eff)
                    MODE_STREAM: if (pix_valid) rgb_d = pix_data;
                    MODE_MASK:   if (pix_valid && mask_bit) rgb_d = pix_data;
                    MODE_BARS:   rgb_d = {{COLOR_W{bar_k[2]}}, {COLOR_W{bar_k[1]}}, {COLOR_W{bar_k[0]}}};
                    default:     rgb_d = '0;
                endcase
            end

            // A starved pixel at the frame boundary keeps the flag set
            if (pix_ready && !pix_valid) begin
                underflow_d = 1'b1;
            end else if (frame_tick) begin
                underflow_d = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= HC_W'(H_TOTAL - 1);
            v_q           <= VC_W'(V_TOTAL - 1);
            mode_q        <= MODE_STREAM;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            rgb_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_r       = rgb_q[RGB_W-1 -: COLOR_W];
    assign vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b       = rgb_q[COLOR_W-1:0];
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_stream_driver.sv
// tb_vga_stream_driver: directed bench for vga_stream_driver on a 14x7 raster
// with a divide-by-2 pixel clock.
module tb_vga_stream_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        mask_bit;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        frame_start;
    logic        underflow;

    int n_cmp = 0;
    int n_bad = 0;

    vga_stream_driver #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .CLK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .mask_bit(mask_bit), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        int          hc;
        int          vc;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        fs;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act_v, exp_v);
        end
    endtask

    function automatic logic [11:0] bars(input int x);
        logic [2:0] k;
        k = 3'(x);
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

    // Hold reset for two edges and release it at a falling edge
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse reset between edges, check reset values, check the restart timing
    task automatic rst_pulse(input string nm);
        #2 rst = 1'b1;
        #1;
        chk({nm, "_hs"}, 32'(vga_hs), 32'd1);
        chk({nm, "_vs"}, 32'(vga_vs), 32'd1);
        chk({nm, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({nm, "_hc"}, 32'(hcount), 32'd0);
        chk({nm, "_vc"}, 32'(vcount), 32'd0);
        chk({nm, "_fs"}, 32'(frame_start), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({nm, "_fs_e1"}, 32'(frame_start), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_fs_e2"}, 32'(frame_start), 32'd1);
        chk({nm, "_hc_e2"}, 32'(hcount), 32'd0);
    endtask

    // Free-running stream run from reset; position derived from the edge count
    task automatic run_stream(input string nm, input int n_edges, input logic [1:0] md0,
                              input int switch_p, input logic [1:0] md1,
                              input int starve_a, input int starve_b,
                              input int uf_on, input int uf_off, output int n_hs);
        int          cnt, p, x, y;
        logic        tk, act, vld, exp_rdy;
        logic [1:0]  cur_md;
        logic [11:0] exp_rgb;
        cnt    = 0;
        n_hs   = 0;
        cur_md = 2'd0;
        en     = 1'b1;
        mode   = md0;
        do_reset();
        for (int e = 1; e <= n_edges; e++) begin
            tk = (e >= 2) && (e % 2 == 0);
            p  = tk ? (e - 2) / 2 : -1;
            x  = tk ? p % 14 : 0;
            y  = tk ? (p / 14) % 7 : 0;
            if (tk && p == switch_p) mode = md1;
            if (tk && p % 98 == 0) cur_md = mode;
            act       = tk && (x < 8) && (y < 4);
            vld       = !(tk && (p == starve_a || p == starve_b));
            pix_valid = vld;
            pix_data  = 12'(cnt);
            mask_bit  = (x >= 4);
            exp_rdy   = act && (cur_md == 2'd0 || cur_md == 2'd2);
            #1;
            chk($sformatf("%s_ready_e%0d", nm, e), 32'(pix_ready), 32'(exp_rdy));
            @(posedge clk); @(negedge clk);
            if (tk) begin
                exp_rgb = 12'h000;
                if (act) begin
                    case (cur_md)
                        2'd0:    if (vld) exp_rgb = 12'(cnt);
                        2'd2:    if (vld && x >= 4) exp_rgb = 12'(cnt);
                        2'd1:    exp_rgb = bars(x);
                        default: exp_rgb = 12'h000;
                    endcase
                end
                chk($sformatf("%s_rgb_p%0d", nm, p), 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
                chk($sformatf("%s_hc_p%0d", nm, p), 32'(hcount), 32'(x));
                chk($sformatf("%s_vc_p%0d", nm, p), 32'(vcount), 32'(y));
                chk($sformatf("%s_uf_p%0d", nm, p), 32'(underflow), 32'(p >= uf_on && p < uf_off));
                if (exp_rdy && vld) begin
                    cnt++;
                    n_hs++;
                end
            end
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        int vi;
        int n_rdy;
        int n_hs;

        // edge, hcount, vcount, hs, vs, rgb, frame_start  (colour-bar mode)
        vecs[0]  = '{1,   0,  0, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[1]  = '{2,   0,  0, 1'b1, 1'b1, 12'h000, 1'b1};
        vecs[2]  = '{3,   0,  0, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[3]  = '{8,   3,  0, 1'b1, 1'b1, 12'h0FF, 1'b0};
        vecs[4]  = '{12,  5,  0, 1'b1, 1'b1, 12'hF0F, 1'b0};
        vecs[5]  = '{16,  7,  0, 1'b1, 1'b1, 12'hFFF, 1'b0};
        vecs[6]  = '{18,  8,  0, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[7]  = '{22, 10,  0, 1'b0, 1'b1, 12'h000, 1'b0};
        vecs[8]  = '{25, 11,  0, 1'b0, 1'b1, 12'h000, 1'b0};
        vecs[9]  = '{26, 12,  0, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[10] = '{32,  1,  1, 1'b1, 1'b1, 12'h00F, 1'b0};
        vecs[11] = '{124, 5,  4, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[12] = '{142, 0,  5, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[13] = '{168, 13, 5, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[14] = '{170, 0,  6, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[15] = '{197, 13, 6, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[16] = '{198, 0,  0, 1'b1, 1'b1, 12'h000, 1'b1};
        vecs[17] = '{199, 0,  0, 1'b1, 1'b1, 12'h000, 1'b0};
        vecs[18] = '{212, 7,  0, 1'b1, 1'b1, 12'hFFF, 1'b0};
        vecs[19] = '{394, 0,  0, 1'b1, 1'b1, 12'h000, 1'b1};

        rst       = 1'b1;
        en        = 1'b1;
        mode      = 2'd1;
        pix_data  = 12'h000;
        pix_valid = 1'b0;
        mask_bit  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hs", 32'(vga_hs), 32'd1);
        chk("reset_vs", 32'(vga_vs), 32'd1);
        chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("reset_hc", 32'(hcount), 32'd0);
        chk("reset_vc", 32'(vcount), 32'd0);
        chk("reset_fs", 32'(frame_start), 32'd0);
        chk("reset_uf", 32'(underflow), 32'd0);
        chk("reset_ready", 32'(pix_ready), 32'd0);

        // Timing and colour bars from the vector table
        do_reset();
        vi    = 0;
        n_rdy = 0;
        for (int e = 1; e <= 394; e++) begin
            @(posedge clk); @(negedge clk);
            if (pix_ready) n_rdy++;
            if (vi < NV && vecs[vi].edge_n == e) begin
                chk($sformatf("vec%0d_hc", vi), 32'(hcount), 32'(vecs[vi].hc));
                chk($sformatf("vec%0d_vc", vi), 32'(vcount), 32'(vecs[vi].vc));
                chk($sformatf("vec%0d_hs", vi), 32'(vga_hs), 32'(vecs[vi].hs));
                chk($sformatf("vec%0d_vs", vi), 32'(vga_vs), 32'(vecs[vi].vs));
                chk($sformatf("vec%0d_rgb", vi), 32'({vga_r, vga_g, vga_b}), 32'(vecs[vi].rgb));
                chk($sformatf("vec%0d_fs", vi), 32'(frame_start), 32'(vecs[vi].fs));
                chk($sformatf("vec%0d_uf", vi), 32'(underflow), 32'd0);
                vi++;
            end
        end
        chk("bars_ready_count", 32'(n_rdy), 32'd0);

        // Plain stream, one full frame
        run_stream("stream", 196, 2'd0, -1, 2'd0, -1, -1, 1000, 1000, n_hs);
        chk("stream_handshakes", 32'(n_hs), 32'd32);

        // Starve at (3,1): flag until the next frame start
        run_stream("uf_a", 222, 2'd0, -1, 2'd0, 17, -1, 17, 98, n_hs);
        chk("uf_a_handshakes", 32'(n_hs), 32'd39);

        // Starve again at next (0,0): set wins over the frame clear
        run_stream("uf_b", 402, 2'd0, -1, 2'd0, 17, 98, 17, 196, n_hs);
        chk("uf_b_handshakes", 32'(n_hs), 32'd67);

        // Masked stream, switching to bars at vcount=2 (latched next frame)
        run_stream("mask", 222, 2'd2, 28, 2'd1, -1, -1, 1000, 1000, n_hs);
        chk("mask_handshakes", 32'(n_hs), 32'd32);

        // Enable freeze for 7 clks mid-line
        mode      = 2'd0;
        en        = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 12'h100;
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            pix_data = 12'(12'h100 + (e - 1) / 2);
            @(posedge clk); @(negedge clk);
        end
        chk("en_pre_hc", 32'(hcount), 32'd4);
        chk("en_pre_rgb", 32'({vga_r, vga_g, vga_b}), 32'h104);
        en        = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 12'h0EE;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("en_off_ready%0d", k), 32'(pix_ready), 32'd0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("en_off_hc%0d", k), 32'(hcount), 32'd4);
            chk($sformatf("en_off_vc%0d", k), 32'(vcount), 32'd0);
            chk($sformatf("en_off_rgb%0d", k), 32'({vga_r, vga_g, vga_b}), 32'h104);
        end
        en        = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 12'h105;
        #1;
        chk("en_resume_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("en_resume_hc", 32'(hcount), 32'd5);
        chk("en_resume_rgb", 32'({vga_r, vga_g, vga_b}), 32'h105);
        repeat (185) begin
            @(posedge clk); @(negedge clk);
        end
        chk("en_e204_fs", 32'(frame_start), 32'd0);
        chk("en_e204_hc", 32'(hcount), 32'd13);
        chk("en_e204_vc", 32'(vcount), 32'd6);
        chk("en_e204_uf", 32'(underflow), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("en_e205_fs", 32'(frame_start), 32'd1);
        chk("en_e205_hc", 32'(hcount), 32'd0);
        chk("en_e205_vc", 32'(vcount), 32'd0);
        pix_valid = 1'b0;

        // Asynchronous reset mid-line, at hcount 6 and inside hsync
        mode = 2'd1;
        do_reset();
        repeat (14) begin
            @(posedge clk); @(negedge clk);
        end
        chk("rst6_pre_hc", 32'(hcount), 32'd6);
        chk("rst6_pre_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFF0);
        rst_pulse("rst_h6");
        repeat (20) begin
            @(posedge clk); @(negedge clk);
        end
        chk("rst10_pre_hc", 32'(hcount), 32'd10);
        chk("rst10_pre_hs", 32'(vga_hs), 32'd0);
        rst_pulse("rst_h10");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_stream_driver.md
Name: vga_stream_driver

Overview:
Parametrised VGA timing and pixel-output engine for the masking display path. It replaces the fixed 4-bit driver with configurable timing, colour depth and pixel-clock division. It pulls pixels from an upstream valid/ready stream and offers four output modes: stream, colour bars, masked stream and blank. It sits between the mask/frame-buffer logic and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
HS_POL, 0, asserted level of vga_hs
VS_POL, 0, asserted level of vga_vs
COLOR_W, 4, bits per colour channel
CLK_DIV, 4, clk cycles per pixel (≥1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  advance enable; low freezes divider, counters and outputs
mode  in  2  0 stream, 1 colour bars, 2 masked stream, 3 blank
pix_data  in  3*COLOR_W  {r,g,b} upstream pixel
pix_valid  in  1  upstream pixel available
pix_ready  out  1  pixel consumed this clk (combinational)
mask_bit  in  1  mode 2: 1 pass pixel, 0 force black
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_r/vga_g/vga_b  out  COLOR_W each  colour outputs
hcount  out  clog2(H_TOTAL)  x position of current output pixel
vcount  out  clog2(V_TOTAL)  y position of current output pixel
frame_start  out  1  one-clk pulse when outputs move to (0,0)
underflow  out  1  sticky: stream starved this frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider div counts 0..CLK_DIV-1 while en=1. tick = en && div==CLK_DIV-1. When CLK_DIV=1, tick = en.
- Internal counters (h,v) advance on tick. h wraps from H_TOTAL-1 to 0. On that wrap, v increments; v wraps from V_TOTAL-1 to 0.
- Reset (async) values: div=0, h=H_TOTAL-1, v=V_TOTAL-1 (so the first tick lands on (0,0)), latched mode=0.
- Reset values of outputs: vga_hs=~HS_POL, vga_vs=~VS_POL, rgb=0, hcount=0, vcount=0, frame_start=0, underflow=0.
- On each tick, every output register is loaded for the new position (h',v') at the same edge, so sync, colour and counts stay aligned.
  - hsync asserted for h' in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for v' in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- active = h'<H_ACTIVE && v'<V_ACTIVE. When active=0, rgb=0 in every mode.
- mode is latched only on the tick into (0,0). A mid-frame change takes effect at the next frame; there is no tearing.
- frame_start is high for exactly the clk whose edge loads (0,0).
- pix_ready = tick && active && latched mode∈{0,2}. A pixel is consumed when pix_ready && pix_valid. The upstream source must not change pix_data while pix_valid && !pix_ready.
- Colour per mode on an active tick:
  - mode 0: rgb = pix_data.
  - mode 2: rgb = mask_bit ? pix_data : 0, sampled at the same edge.
  - mode 1: bar index k = h'/(H_ACTIVE/8), implemented by constant comparisons. r = all-ones if k[2], g if k[1], b if k[0], otherwise 0. pix_ready stays 0.
  - mode 3: rgb = 0 with syncs running. pix_ready stays 0.
- Underflow:
  - pix_ready && !pix_valid gives rgb=0 for that pixel and sets underflow.
  - underflow clears on the tick into (0,0). If that same pixel also starves, underflow is set instead (set wins).
- en=0: no tick and pix_ready=0; all state and outputs hold. Resuming continues from the same div value.
- rst mid-frame: outputs go to reset values immediately, with no clock needed. The first tick after release produces frame_start.

Test Plan:
Sim parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); CLK_DIV=2; HS_POL=VS_POL=0.
1. Timing: release rst with en=1, mode=1 -> frame_start on the 2nd rising edge after release, then every 196 clks. vga_hs=0 only for hcount 10..11 (4 clks per line). vga_vs=0 only for vcount 5.
2. Colour bars: mode=1, COLOR_W=4 -> hcount=5 gives r=F, g=0, b=F; hcount=3 gives r=0, g=F, b=F; hcount 8..13 and vcount 4..6 give rgb=0; pix_ready never asserts.
3. Stream: mode=0, pix_valid=1, pix_data incrementing from 0 on each handshake -> exactly 32 handshakes per frame, pixel (x,y) shows value y*8+x, underflow stays 0.
4. Underflow: mode=0, pix_valid held 0 only at pixel (3,1) -> rgb=0 there, underflow=1 from that edge until the next frame_start edge, then 0. Same test with a starve at (0,0) -> underflow stays 1.
5. Mask / mode latch: mode=2 with mask_bit=0 for x<4 -> left half black, right half data, 32 handshakes. Switch mode 2→1 at vcount=2 -> output unchanged until next frame_start, then bars.
6. en and async reset: drop en for 7 clks mid-line -> hcount, vcount and rgb frozen, no pix_ready, frame period extends by 7. Pulse rst between clock edges at hcount=6 -> vga_hs=1, rgb=0, counts=0 immediately, and frame_start on the 2nd edge after release.
